sort_mem_slave: RTL and testbench

//  Parametrised memory slave for the sort_circuit read/write channel interface (AR/R/AW/W/B).

---
 rtl/sort_mem_pkg.sv | 27 ++
 rtl/sort_mem_lfsr.sv | 21 ++
 rtl/sort_mem_slave.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_sort_mem_slave.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_mem_pkg.sv
// Shared encodings for sort_mem_slave: response codes, error modes, FSM states.
package sort_mem_pkg;

  localparam int CNT_WDTH = 16;
  localparam int LAT_WDTH = 16;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  localparam logic [1:0] ERR_MODE_NORMAL  = 2'b00;
  localparam logic [1:0] ERR_MODE_SUCCESS = 2'b01;
  localparam logic [1:0] ERR_MODE_ERROR   = 2'b10;
  localparam logic [1:0] ERR_MODE_WINDOW  = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_WAIT = 2'b01,
    R_RESP = 2'b10
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'b00,
    WR_WAIT = 2'b01,
    WR_RESP = 2'b10
  } wr_state_t;

endpackage

// File: rtl/sort_mem_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11); low bits drive stall injection in sort_mem_slave.
module sort_mem_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] stall
);

  logic [15:0] q;
  logic        fb;

  assign fb    = q[15] ^ q[13] ^ q[12] ^ q[10];
  assign stall = q[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= SEED;
    else        q <= {q[14:0], fb};
  end

endmodule

// File: rtl/sort_mem_slave.sv
// Parametrised AR/R/AW/W/B memory slave with latency, error modes, preload and counters.
// Optional random ready/latency stalls when SORT_MEM_STALL_EN is defined.
//
// state   | meaning
// R_IDLE  | ar_ready high, waiting for a read address
// R_WAIT  | read latency countdown
// R_RESP  | r_valid held until r_ready
// WR_IDLE | collecting AW and W into their holding registers
// WR_WAIT | write latency countdown once both are held
// WR_RESP | b_valid held until b_ready
module sort_mem_slave
  import sort_mem_pkg::*;
#(
  parameter int          ADDR_WDTH  = 4,
  parameter int          DATA_WDTH  = 32,
  parameter int          RESP_WDTH  = 1,
  parameter int          DEPTH      = 2 ** ADDR_WDTH,
  parameter int          RD_LAT     = 1,
  parameter int          WR_LAT     = 1,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           err_mode,
  input  logic [ADDR_WDTH-1:0] err_lo,
  input  logic [ADDR_WDTH-1:0] err_hi,
  input  logic                 init_we,
  input  logic [ADDR_WDTH-1:0] init_addr,
  input  logic [DATA_WDTH-1:0] init_data,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_WDTH-1:0] ar_address,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_WDTH-1:0] aw_address,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [RESP_WDTH-1:0] b_resp,
  output logic [CNT_WDTH-1:0]  rd_count,
  output logic [CNT_WDTH-1:0]  wr_count,
  output logic                 switch_case_default
);

  logic [DATA_WDTH-1:0] mem [DEPTH];
  logic                 alive;
  logic [3:0]           stall;

`ifdef SORT_MEM_STALL_EN
  sort_mem_lfsr #(.SEED(STALL_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall)
  );
`else
  assign stall = 4'b0000;
`endif

  function automatic logic addr_err(input logic [ADDR_WDTH-1:0] a,
                                    input logic [1:0] mode,
                                    input logic [ADDR_WDTH-1:0] lo,
                                    input logic [ADDR_WDTH-1:0] hi);
    if (32'(a) >= DEPTH) return RESP_ERR;
    case (mode)
      ERR_MODE_NORMAL:  return RESP_OKAY;
      ERR_MODE_SUCCESS: return RESP_OKAY;
      ERR_MODE_ERROR:   return RESP_ERR;
      default:          return (a >= lo) && (a <= hi);
    endcase
  endfunction

  logic ar_err, aw_err;
  assign ar_err = addr_err(ar_address, err_mode, err_lo, err_hi);
  assign aw_err = addr_err(aw_address, err_mode, err_lo, err_hi);

  // read path
  rd_state_t            rd_state, rd_state_nxt;
  logic [ADDR_WDTH-1:0] rd_addr, rd_addr_nxt;
  logic                 rd_err, rd_err_nxt;
  logic [LAT_WDTH-1:0]  rd_cnt, rd_cnt_nxt;
  logic                 rd_xtra, rd_xtra_nxt;
  logic                 r_valid_nxt;
  logic [DATA_WDTH-1:0] r_data_nxt;
  logic [RESP_WDTH-1:0] r_resp_nxt;
  logic [CNT_WDTH-1:0]  rd_count_nxt;
  logic                 rd_illegal;

  assign ar_ready = alive && (rd_state == R_IDLE) && !stall[0];

  always_comb begin
    rd_state_nxt = rd_state;
    rd_addr_nxt  = rd_addr;
    rd_err_nxt   = rd_err;
    rd_cnt_nxt   = rd_cnt;
    rd_xtra_nxt  = rd_xtra;
    r_valid_nxt  = r_valid;
    r_data_nxt   = r_data;
    r_resp_nxt   = r_resp;
    rd_count_nxt = rd_count;
    rd_illegal   = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (ar_valid && ar_ready) begin
          rd_addr_nxt  = ar_address;
          rd_err_nxt   = ar_err;
          rd_cnt_nxt   = LAT_WDTH'(RD_LAT - 1);
          rd_state_nxt = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rd_cnt != '0) begin
          rd_cnt_nxt = rd_cnt - 1'b1;
        end else if (stall[3] && !rd_xtra) begin
          rd_xtra_nxt = 1'b1;
        end else begin
          // sampled before any same-edge commit lands, so a colliding write reads old data
          rd_xtra_nxt  = 1'b0;
          r_valid_nxt  = 1'b1;
          r_data_nxt   = rd_err ? '0 : mem[rd_addr];
          r_resp_nxt   = rd_err ? '1 : '0;
          rd_state_nxt = R_RESP;
        end
      end
      R_RESP: begin
        if (r_ready) begin
          r_valid_nxt  = 1'b0;
          rd_count_nxt = rd_count + 1'b1;
          rd_state_nxt = R_IDLE;
        end
      end
      default: begin
        rd_illegal   = 1'b1;
        r_valid_nxt  = 1'b0;
        rd_state_nxt = R_IDLE;
      end
    endcase
  end

  // write path
  wr_state_t            wr_state, wr_state_nxt;
  logic                 aw_held, aw_held_nxt, w_held, w_held_nxt;
  logic [ADDR_WDTH-1:0] wr_addr, wr_addr_nxt;
  logic                 wr_err, wr_err_nxt;
  logic [DATA_WDTH-1:0] wr_data, wr_data_nxt;
  logic [LAT_WDTH-1:0]  wr_cnt, wr_cnt_nxt;
  logic                 wr_xtra, wr_xtra_nxt;
  logic                 b_valid_nxt;
  logic [RESP_WDTH-1:0] b_resp_nxt;
  logic [CNT_WDTH-1:0]  wr_count_nxt;
  logic                 commit;
  logic                 wr_illegal;

  assign aw_ready = alive && !aw_held && !b_valid && !stall[1];
  assign w_ready  = alive && !w_held && !b_valid && !stall[2];

  always_comb begin
    wr_state_nxt = wr_state;
    aw_held_nxt  = aw_held;
    w_held_nxt   = w_held;
    wr_addr_nxt  = wr_addr;
    wr_err_nxt   = wr_err;
    wr_data_nxt  = wr_data;
    wr_cnt_nxt   = wr_cnt;
    wr_xtra_nxt  = wr_xtra;
    b_valid_nxt  = b_valid;
    b_resp_nxt   = b_resp;
    wr_count_nxt = wr_count;
    commit       = 1'b0;
    wr_illegal   = 1'b0;
    if (aw_valid && aw_ready) begin
      aw_held_nxt = 1'b1;
      wr_addr_nxt = aw_address;
      wr_err_nxt  = aw_err;
    end
    if (w_valid && w_ready) begin
      w_held_nxt  = 1'b1;
      wr_data_nxt = w_data;
    end
    case (wr_state)
      WR_IDLE: begin
        if (aw_held_nxt && w_held_nxt) begin
          wr_cnt_nxt   = LAT_WDTH'(WR_LAT - 1);
          wr_state_nxt = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (wr_cnt != '0) begin
          wr_cnt_nxt = wr_cnt - 1'b1;
        end else if (stall[3] && !wr_xtra) begin
          wr_xtra_nxt = 1'b1;
        end else begin
          wr_xtra_nxt  = 1'b0;
          commit       = !wr_err;
          b_valid_nxt  = 1'b1;
          b_resp_nxt   = wr_err ? '1 : '0;
          wr_state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_ready) begin
          b_valid_nxt  = 1'b0;
          aw_held_nxt  = 1'b0;
          w_held_nxt   = 1'b0;
          wr_count_nxt = wr_count + 1'b1;
          wr_state_nxt = WR_IDLE;
        end
      end
      default: begin
        wr_illegal   = 1'b1;
        b_valid_nxt  = 1'b0;
        aw_held_nxt  = 1'b0;
        w_held_nxt   = 1'b0;
        wr_state_nxt = WR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive               <= 1'b0;
      rd_state            <= R_IDLE;
      rd_addr             <= '0;
      rd_err              <= 1'b0;
      rd_cnt              <= '0;
      rd_xtra             <= 1'b0;
      r_valid             <= 1'b0;
      r_data              <= '0;
      r_resp              <= '0;
      rd_count            <= '0;
      wr_state            <= WR_IDLE;
      aw_held             <= 1'b0;
      w_held              <= 1'b0;
      wr_addr             <= '0;
      wr_err              <= 1'b0;
      wr_data             <= '0;
      wr_cnt              <= '0;
      wr_xtra             <= 1'b0;
      b_valid             <= 1'b0;
      b_resp              <= '0;
      wr_count            <= '0;
      switch_case_default <= 1'b0;
    end else begin
      alive               <= 1'b1;
      rd_state            <= rd_state_nxt;
      rd_addr             <= rd_addr_nxt;
      rd_err              <= rd_err_nxt;
      rd_cnt              <= rd_cnt_nxt;
      rd_xtra             <= rd_xtra_nxt;
      r_valid             <= r_valid_nxt;
      r_data              <= r_data_nxt;
      r_resp              <= r_resp_nxt;
      rd_count            <= rd_count_nxt;
      wr_state            <= wr_state_nxt;
      aw_held             <= aw_held_nxt;
      w_held              <= w_held_nxt;
      wr_addr             <= wr_addr_nxt;
      wr_err              <= wr_err_nxt;
      wr_data             <= wr_data_nxt;
      wr_cnt              <= wr_cnt_nxt;
      wr_xtra             <= wr_xtra_nxt;
      b_valid             <= b_valid_nxt;
      b_resp              <= b_resp_nxt;
      wr_count            <= wr_count_nxt;
      switch_case_default <= switch_case_default | rd_illegal | wr_illegal;
    end
  end

  // memory is deliberately not reset; preload wins over a same-address channel commit
  always_ff @(posedge clk) begin
    if (init_we && (32'(init_addr) < DEPTH))
      mem[init_addr] <= init_data;
    if (commit && !(init_we && (init_addr == wr_addr)))
      mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_sort_mem_slave.sv
// Scoreboard bench for sort_mem_slave (DEPTH=12, RD_LAT=3, WR_LAT=2, stalls disabled).
module tb_sort_mem_slave;

  localparam int AW = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    err_mode = 2'b00;
  logic [AW-1:0] err_lo = '0, err_hi = '0;
  logic          init_we = 1'b0;
  logic [AW-1:0] init_addr = '0;
  logic [DW-1:0] init_data = '0;
  logic          ar_valid = 1'b0, ar_ready;
  logic [AW-1:0] ar_address = '0;
  logic          r_valid, r_ready = 1'b1;
  logic [DW-1:0] r_data;
  logic [0:0]    r_resp;
  logic          aw_valid = 1'b0, aw_ready;
  logic [AW-1:0] aw_address = '0;
  logic          w_valid = 1'b0, w_ready;
  logic [DW-1:0] w_data = '0;
  logic          b_valid, b_ready = 1'b1;
  logic [0:0]    b_resp;
  logic [15:0]   rd_count, wr_count;
  logic          switch_case_default;

  sort_mem_slave #(
    .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(1), .DEPTH(12),
    .RD_LAT(3), .WR_LAT(2), .STALL_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .err_mode(err_mode), .err_lo(err_lo), .err_hi(err_hi),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .rd_count(rd_count), .wr_count(wr_count), .switch_case_default(switch_case_default)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [32:0] rq[$];
  logic        bq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // monitor: a valid&ready seen at negedge completes on the next rising edge
  always @(negedge clk) begin
    if (rst_n && r_valid && r_ready) begin
      if (rq.size() == 0) check("r_unexpected", 64'(r_valid), 64'(0));
      else begin
        logic [32:0] e;
        e = rq.pop_front();
        check("r_data_resp", {31'b0, r_resp, r_data}, {31'b0, e});
      end
    end
    if (rst_n && b_valid && b_ready) begin
      if (bq.size() == 0) check("b_unexpected", 64'(b_valid), 64'(0));
      else begin
        logic e;
        e = bq.pop_front();
        check("b_resp", 64'(b_resp), 64'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    step();
    init_we = 1'b0;
  endtask

  task automatic start_read(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic er,
                            input bit push);
    int n;
    n = 0;
    if (push) rq.push_back({er, ed});
    ar_address = a;
    ar_valid = 1'b1;
    while (!ar_ready && n < 100) begin step(); n++; end
    if (!ar_ready) check("ar_ready_timeout", 64'(ar_ready), 64'(1));
    step();
    ar_valid = 1'b0;
  endtask

  task automatic wait_rvalid(output int lat);
    lat = 0;
    while (!r_valid && lat < 100) begin step(); lat++; end
    if (!r_valid) check("r_valid_timeout", 64'(r_valid), 64'(1));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic er);
    int lat;
    start_read(a, ed, er, 1'b1);
    wait_rvalid(lat);
    check("rd_latency", 64'(lat), 64'(3));
    step();
    exp_rd++;
    check("rd_count", 64'(rd_count), 64'(exp_rd));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int gap,
                          input logic er);
    int n;
    int lat;
    bq.push_back(er);
    aw_address = a;
    w_data = d;
    n = 0;
    if (gap == 0) begin
      aw_valid = 1'b1; w_valid = 1'b1;
      while (!(aw_ready && w_ready) && n < 100) begin step(); n++; end
      step();
      aw_valid = 1'b0; w_valid = 1'b0;
    end else begin
      w_valid = 1'b1;
      while (!w_ready && n < 100) begin step(); n++; end
      step();
      w_valid = 1'b0;
      repeat (gap - 1) step();
      check("aw_ready_with_w_held", 64'(aw_ready), 64'(1));
      aw_valid = 1'b1;
      step();
      aw_valid = 1'b0;
    end
    lat = 0;
    while (!b_valid && lat < 100) begin step(); lat++; end
    if (!b_valid) check("b_valid_timeout", 64'(b_valid), 64'(1));
    check("wr_latency", 64'(lat), 64'(2));
    step();
    exp_wr++;
    check("wr_count", 64'(wr_count), 64'(exp_wr));
  endtask

  initial begin
    int lat;
    int seen;
    int rc0;

    // reset values
    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs",
          {27'b0, ar_ready, aw_ready, w_ready, r_valid, b_valid, switch_case_default, r_resp, b_resp},
          64'(0));
    check("reset_data_counts", {r_data, rd_count, wr_count}, 64'(0));
    repeat (2) step();
    rst_n = 1'b1;
    check("ready_before_first_edge", {ar_ready, aw_ready, w_ready}, 64'(0));
    step();
    check("ready_after_release", {ar_ready, aw_ready, w_ready}, 64'h7);

    // 1: preload + RD_LAT=3
    preload(4'd3, 32'hDEAD_BEEF);
    do_read(4'd3, 32'hDEAD_BEEF, 1'b0);

    // 2: W two cycles before AW
    do_write(4'd7, 32'h5, 2, 1'b0);
    check("t2_wr_count_one", 64'(wr_count), 64'(1));
    do_read(4'd7, 32'h5, 1'b0);

    // 3: window errors
    preload(4'd5, 32'h0000_1234);
    err_mode = 2'b11; err_lo = 4'd4; err_hi = 4'd6;
    do_write(4'd5, 32'hFFFF_FFFF, 0, 1'b1);
    do_read(4'd7, 32'h5, 1'b0);
    do_read(4'd4, 32'h0, 1'b1);
    do_read(4'd6, 32'h0, 1'b1);
    do_read(4'd3, 32'hDEAD_BEEF, 1'b0);
    err_lo = 4'd9; err_hi = 4'd2;
    do_read(4'd5, 32'h0000_1234, 1'b0);
    err_mode = 2'b10;
    do_read(4'd3, 32'h0, 1'b1);
    do_write(4'd3, 32'h0BAD_0BAD, 0, 1'b1);
    err_mode = 2'b00;
    do_read(4'd3, 32'hDEAD_BEEF, 1'b0);

    // 4: r_ready back-pressure
    r_ready = 1'b0;
    start_read(4'd3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_rvalid(lat);
    rc0 = int'(rd_count);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold", {r_valid, ar_ready, r_data}, {1'b1, 1'b0, 32'hDEAD_BEEF});
    end
    r_ready = 1'b1;
    step();
    check("t4_rd_count_once", 64'(rd_count), 64'(rc0 + 1));
    step();
    check("t4_rd_count_stable", 64'(rd_count), 64'(rc0 + 1));
    exp_rd = rc0 + 1;

    // 5: reset during R_WAIT
    preload(4'd2, 32'hCAFE_0002);
    start_read(4'd2, 32'h0, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check("t5_in_reset", {r_valid, ar_ready, rd_count, wr_count}, 64'(0));
    exp_rd = 0; exp_wr = 0;
    repeat (2) step();
    rst_n = 1'b1;
    check("t5_ready_low_at_release", 64'(ar_ready), 64'(0));
    step();
    check("t5_ar_ready_after", 64'(ar_ready), 64'(1));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (r_valid) seen++;
      step();
    end
    check("t5_no_r_valid", 64'(seen), 64'(0));
    do_read(4'd2, 32'hCAFE_0002, 1'b0);

    // 6: out of range beats always_success
    err_mode = 2'b01;
    do_read(4'd13, 32'h0, 1'b1);
    do_read(4'd12, 32'h0, 1'b1);
    preload(4'd11, 32'h1111_0011);
    do_read(4'd11, 32'h1111_0011, 1'b0);
    do_write(4'd12, 32'h5555_5555, 1, 1'b1);
    do_write(4'd11, 32'hABCD_0011, 0, 1'b0);
    do_read(4'd11, 32'hABCD_0011, 1'b0);

    repeat (3) step();
    check("scoreboard_drained", 64'(rq.size() + bq.size()), 64'(0));
    check("switch_case_default", 64'(switch_case_default), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
